// File: rtl/case_1_mul_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : case_1_mul_share_arb_pkg
// Purpose  : Shared defaults and helpers for the shared-multiplier arbiter:
//            default requester count and operand/result widths, plus a
//            constant-foldable clog2 used to size requester indices.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package case_1_mul_share_arb_pkg;

   localparam int DEF_N_REQ = 4;   // number of requesters
   localparam int DEF_A_W   = 9;   // signed operand A width
   localparam int DEF_B_W   = 4;   // signed operand B width
   localparam int DEF_P_W   = 9;   // truncated product width

   // Ceiling log2; callers only pass values >= 2, so the result is >= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/case_1_mul_9s_4s_9_1_1.sv
`default_nettype none
// ============================================================================
// Module   : case_1_mul_9s_4s_9_1_1
// Purpose  : Combinational signed multiplier core. Forms the full-width
//            signed product and returns its low DOUT_W bits (wraps, no
//            saturation).
// Ports    : din0_i - signed operand A (DIN0_W bits)
//            din1_i - signed operand B (DIN1_W bits)
//            dout_o - low DOUT_W bits of the signed product
// Revision : 1.0 - initial release
// ============================================================================
module case_1_mul_9s_4s_9_1_1 #(
   parameter int DIN0_W = 9,
   parameter int DIN1_W = 4,
   parameter int DOUT_W = 9
) (
   input  logic [DIN0_W-1:0] din0_i,
   input  logic [DIN1_W-1:0] din1_i,
   output logic [DOUT_W-1:0] dout_o
);

   logic signed [DIN0_W+DIN1_W-1:0] full_prod;

   // Both operands are signed, so they are sign-extended to the full
   // product width before the multiply.
   assign full_prod = $signed(din0_i) * $signed(din1_i);
   assign dout_o    = full_prod[DOUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/case_1_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : case_1_rr_arb
// Purpose  : Round-robin arbiter. Grants the first asserted request at or
//            above the pointer (wrapping), combinationally. The pointer moves
//            to one past the granted index only when advance_i is high.
// Ports    : clk_i     - clock, rising edge
//            rst_ni    - asynchronous active-low reset (pointer -> 0)
//            req_i     - per-requester request
//            advance_i - the current grant was accepted this cycle
//            grant_o   - one-hot grant (all zero when no request)
//            index_o   - binary index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module case_1_rr_arb
   import case_1_mul_share_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_REQ-1:0] req_i,
   input  logic             advance_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] index_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W:0]   cand_sum;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   // Scan N_REQ positions starting at the pointer; the extra sum bit lets the
   // wrap work for non-power-of-two requester counts.
   always_comb begin
      grant_o  = '0;
      index_o  = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
            cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
         end
         cand_idx = cand_sum[IDX_W-1:0];
         if (!found && req_i[cand_idx]) begin
            found             = 1'b1;
            index_o           = cand_idx;
            grant_o[cand_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = (index_o == IDX_W'(N_REQ-1)) ? '0 : index_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/case_1_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : case_1_mul_share_arb
// Purpose  : One signed A_W x B_W multiplier shared by N_REQ requesters via
//            round-robin arbitration, behind a two-stage valid/ready pipeline
//            (stage 1: operand capture, stage 2: product register).
// Ports    : ap_clk    - clock, rising edge
//            ap_rst_n  - asynchronous active-low reset
//            req_valid - per-requester operand valid
//            req_a     - packed operand A, requester i at [i*A_W +: A_W]
//            req_b     - packed operand B, requester i at [i*B_W +: B_W]
//            req_ready - per-requester accept (at most one bit set)
//            res_valid - result valid
//            res_data  - low P_W bits of the signed product
//            res_id    - index of the requester that produced res_data
//            res_ready - downstream accept
//            idle      - no pending request and both stages empty
// Revision : 1.0 - initial release
// ============================================================================
module case_1_mul_share_arb
   import case_1_mul_share_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int A_W   = DEF_A_W,
   parameter int B_W   = DEF_B_W,
   parameter int P_W   = DEF_P_W
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*A_W-1:0]      req_a,
   input  logic [N_REQ*B_W-1:0]      req_b,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      res_valid,
   output logic [P_W-1:0]            res_data,
   output logic [clog2(N_REQ)-1:0]   res_id,
   input  logic                      res_ready,
   output logic                      idle
);

   localparam int IDX_W = clog2(N_REQ);

   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             adv;
   logic             s1_free;
   logic             req_xfer;
   logic [A_W-1:0]   sel_a;
   logic [B_W-1:0]   sel_b;
   logic [P_W-1:0]   prod;

   logic             s1_valid_q;
   logic [A_W-1:0]   s1_a_q;
   logic [B_W-1:0]   s1_b_q;
   logic [IDX_W-1:0] s1_id_q;
   logic             s2_valid_q;
   logic [P_W-1:0]   res_data_q;
   logic [IDX_W-1:0] res_id_q;

   case_1_rr_arb #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk_i     (ap_clk),
      .rst_ni    (ap_rst_n),
      .req_i     (req_valid),
      .advance_i (req_xfer),
      .grant_o   (grant),
      .index_o   (grant_idx)
   );

   assign adv     = !s2_valid_q || res_ready;
   assign s1_free = !s1_valid_q || adv;

   // Gating with ap_rst_n keeps req_ready low during reset even though the
   // emptied stage 1 would otherwise look free.
   assign req_ready = grant & {N_REQ{s1_free && ap_rst_n}};
   assign req_xfer  = |(req_valid & req_ready);

   // One-hot AND-OR operand select driven by the grant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*A_W +: A_W];
            sel_b = req_b[i*B_W +: B_W];
         end
      end
   end

   // Stage 1: operand capture. A new transfer wins over draining, which is
   // what lets result, move and accept all happen in the same cycle.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
      end else if (req_xfer) begin
         s1_valid_q <= 1'b1;
         s1_a_q     <= sel_a;
         s1_b_q     <= sel_b;
         s1_id_q    <= grant_idx;
      end else if (adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   case_1_mul_9s_4s_9_1_1 #(
      .DIN0_W (A_W),
      .DIN1_W (B_W),
      .DOUT_W (P_W)
   ) u_mul (
      .din0_i (s1_a_q),
      .din1_i (s1_b_q),
      .dout_o (prod)
   );

   // Stage 2: product register; holds while blocked by res_ready.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s2_valid_q <= 1'b0;
         res_data_q <= '0;
         res_id_q   <= '0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         res_data_q <= prod;
         res_id_q   <= s1_id_q;
      end
   end

   assign res_valid = s2_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign idle      = !ap_rst_n || (!(|req_valid) && !s1_valid_q && !s2_valid_q);

endmodule
`default_nettype wire

// File: doc/case_1_mul_share_arb.md
CASE_1_MUL_SHARE_ARB -- requirements
Module: case_1_mul_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter A_W, default 9: signed operand A width.
REQ-003 SHALL have parameter B_W, default 4: signed operand B width.
REQ-004 SHALL have parameter P_W, default 9: result width, the low P_W bits of the full signed product.
REQ-005 SHALL have port ap_clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, N_REQ bits: per-requester operand valid.
REQ-008 SHALL have port req_a, input, N_REQ*A_W bits: packed operand A; requester i occupies slice [i*A_W +: A_W].
REQ-009 SHALL have port req_b, input, N_REQ*B_W bits: packed operand B, packed the same way.
REQ-010 SHALL have port req_ready, output, N_REQ bits: per-requester accept; at most one bit set per cycle.
REQ-011 SHALL have port res_valid, output, 1 bit: result valid.
REQ-012 SHALL have port res_data, output, P_W bits: truncated signed product.
REQ-013 SHALL have port res_id, output, clog2(N_REQ) bits: index of the requester that produced res_data.
REQ-014 SHALL have port res_ready, input, 1 bit: downstream accept.
REQ-015 SHALL have port idle, output, 1 bit: high when no request is pending and both pipeline stages are empty.

Function
REQ-016 SHALL share one signed A_W x B_W multiplier among all requesters using round-robin arbitration.
REQ-017 Transfer rules: a request transfer SHALL occur when req_valid[i] and req_ready[i] are both high; a result transfer SHALL occur when res_valid and res_ready are both high.
REQ-018 Grant: SHALL grant the first requester with req_valid set, searching upward from pointer rr_ptr and wrapping from N_REQ-1 to 0; the grant SHALL be combinational from req_valid and rr_ptr.
REQ-019 req_ready[i] SHALL equal grant[i] AND s1_free, where s1_free = !s1_valid OR adv.
REQ-020 adv SHALL equal !s2_valid OR res_ready (pipeline advance condition).
REQ-021 Stage 1, on a request transfer, SHALL register A, B and id and set s1_valid.
REQ-022 Stage 1 SHALL clear s1_valid when adv is high and no new request transfer occurs in that cycle.
REQ-023 Stage 2, when adv is high, SHALL load s2_valid from s1_valid, res_data from the product of the stage-1 operands, and res_id from the stage-1 id.
REQ-024 res_valid SHALL equal s2_valid.
REQ-025 Latency SHALL be 2 cycles from request transfer to res_valid.
REQ-026 Throughput SHALL be 1 result per cycle when res_ready is held high.
REQ-027 Arithmetic: product = $signed(A) * $signed(B), computed at full A_W+B_W width; res_data SHALL be bits [P_W-1:0] of it, with no saturation.
REQ-028 rr_ptr SHALL become (granted index + 1) mod N_REQ only on a request transfer; otherwise it SHALL hold.
REQ-029 Backpressure: while res_ready is low and both stages are full, req_ready SHALL be all zero and res_data, res_id and stage-1 contents SHALL hold stable.
REQ-030 Simultaneous events: in a cycle with a result transfer, a stage-1 to stage-2 move and a new request transfer, all three SHALL complete, with no bubble and no data loss.
REQ-031 A requester that deasserts req_valid before being accepted SHALL lose its slot; no state is retained for it.
REQ-032 Fairness: with all N_REQ requesters continuously valid, the grant sequence SHALL be rr_ptr, rr_ptr+1, ... (mod N_REQ), so each requester is served once per N_REQ accepted transfers.

Reset
REQ-033 On ap_rst_n low, asynchronously: s1_valid=0, s2_valid=0, res_data=0, res_id=0, rr_ptr=0.
REQ-034 While ap_rst_n is low, the combinational outputs SHALL be req_ready=0 and idle=1.
REQ-035 Reset asserted mid-operation SHALL drop in-flight operations without producing a result.
REQ-036 The first grant after reset release SHALL search from index 0.

Structure
REQ-037 A shared package SHALL hold the default widths A_W, B_W, P_W and N_REQ, and a function clog2.
REQ-038 Round-robin grant and pointer logic SHALL be a sub-module named case_1_rr_arb, taking req, advance and N_REQ, and producing grant and index.
REQ-039 The multiply SHALL be the team's existing combinational core case_1_mul_9s_4s_9_1_1, instantiated between stage 1 and stage 2, with no other arithmetic in the top level.

Verification
REQ-040 Single request: req0 A=9'h005, B=4'h3 -> 2 cycles later res_valid=1, res_data=9'h00F, res_id=0.
REQ-041 Sign/truncation cases:
- A=9'h100 (-256), B=4'h8 (-8) -> res_data=9'h000;
- A=100, B=7 -> res_data=9'h0BC;
- A=9'h1FD (-3), B=5 -> res_data=9'h1F1.
REQ-042 All 4 requesters valid continuously with res_ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles, and rr_ptr wraps.
REQ-043 Backpressure: res_ready=0 for 5 cycles with 3 requesters valid -> exactly 2 ops accepted, req_ready=0 thereafter, outputs stable; after res_ready returns to 1, all results arrive in order with no loss or duplication.
REQ-044 Reset mid-stream: assert ap_rst_n low with both stages full -> res_valid=0 immediately; after release, no stale result appears and the first grant goes to the lowest valid index.
